// File: rtl/fft_bfly_sequencer_if.sv
// Control bundle between the FFT top-level, the data RAM and the butterfly datapath.
// The sequencer drives everything except start.
interface fft_bfly_sequencer_if #(
  parameter int LOG2N = 5
);
  logic             start;
  logic             busy;
  logic             done;
  logic [2:0]       stage;
  logic             rd_valid;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic [LOG2N-2:0] tw_idx;
  logic             bf_en;
  logic             bf_clr;
  logic             wr_valid;
  logic [LOG2N-1:0] wr_addr_a;
  logic [LOG2N-1:0] wr_addr_b;

  modport master (
    input  start,
    output busy, done, stage, rd_valid, rd_addr_a, rd_addr_b, tw_idx,
           bf_en, bf_clr, wr_valid, wr_addr_a, wr_addr_b
  );

  modport slave (
    output start,
    input  busy, done, stage, rd_valid, rd_addr_a, rd_addr_b, tw_idx,
           bf_en, bf_clr, wr_valid, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/fft_bfly_sequencer.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT with one butterfly unit.
// Issues read addresses and twiddles, and write-back addresses delayed by RAM plus butterfly latency.
module fft_bfly_sequencer #(
  parameter int LOG2N  = 5,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 4
) (
  input  logic                 clock_c,
  input  logic                 reset_n,
  fft_bfly_sequencer_if.master bus
);
  localparam int HALF   = 1 << (LOG2N - 1);
  localparam int WR_LAT = RD_LAT + BF_LAT;
  localparam int DW     = ($clog2(WR_LAT) > 0) ? $clog2(WR_LAT) : 1;
  localparam int AW     = LOG2N;
  localparam int TW     = LOG2N - 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } wr_ent_t;

  state_t                    state_q, state_d;
  logic [2:0]                stage_q, stage_d;
  logic [TW-1:0]             bfly_q, bfly_d;
  logic [DW-1:0]             drain_q, drain_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      bf_clr_q, bf_clr_d;
  logic                      rd_valid_q, rd_valid_d;
  logic [AW-1:0]             rd_addr_a_q, rd_addr_a_d;
  logic [AW-1:0]             rd_addr_b_q, rd_addr_b_d;
  logic [TW-1:0]             tw_cur_q, tw_cur_d;
  logic [RD_LAT-1:0][TW-1:0] tw_pipe_q, tw_pipe_d;
  wr_ent_t [WR_LAT-1:0]      wr_pipe_q, wr_pipe_d;
  logic [AW-1:0]             addr_a_nxt, addr_b_nxt;
  logic [TW-1:0]             tw_nxt;

  // Upper leg inserts a zero at bit s of b; lower leg is span above it.
  function automatic void bfly_addr(input  logic [2:0]    s,
                                    input  logic [TW-1:0] b,
                                    output logic [AW-1:0] a_lo,
                                    output logic [AW-1:0] a_hi,
                                    output logic [TW-1:0] tw);
    logic [AW-1:0] span, pos, grp, b_ext;
    b_ext = {1'b0, b};
    span  = AW'(1) << s;
    pos   = b_ext & (span - AW'(1));
    grp   = b_ext >> s;
    a_lo  = (grp << (s + 3'd1)) | pos;
    a_hi  = a_lo + span;
    tw    = TW'(pos << (3'(TW) - s));
  endfunction

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          stage_d = '0;
          bfly_d  = '0;
        end
      end
      RUN: begin
        if (bfly_q == TW'(HALF - 1)) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          bfly_d = bfly_q + TW'(1);
        end
      end
      DRAIN: begin
        if (drain_q == DW'(WR_LAT - 1)) begin
          if (stage_q == 3'(LOG2N - 1)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            stage_d = stage_q + 3'd1;
            bfly_d  = '0;
          end
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        stage_d = '0;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are computed from the next state so they register in step with it.
    busy_d     = (state_d == RUN) || (state_d == DRAIN);
    done_d     = (state_d == DONE);
    bf_clr_d   = (state_q == IDLE) && (state_d == RUN);
    rd_valid_d = (state_d == RUN);
    bfly_addr(stage_d, bfly_d, addr_a_nxt, addr_b_nxt, tw_nxt);
    rd_addr_a_d = rd_valid_d ? addr_a_nxt : '0;
    rd_addr_b_d = rd_valid_d ? addr_b_nxt : '0;
    tw_cur_d    = rd_valid_d ? tw_nxt : '0;

    tw_pipe_d[0] = tw_cur_q;
    for (int i = 1; i < RD_LAT; i++) begin
      tw_pipe_d[i] = tw_pipe_q[i-1];
    end
    wr_pipe_d[0] = {rd_valid_q, rd_addr_a_q, rd_addr_b_q};
    for (int i = 1; i < WR_LAT; i++) begin
      wr_pipe_d[i] = wr_pipe_q[i-1];
    end
  end

  always_ff @(posedge clock_c) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      stage_q     <= '0;
      bfly_q      <= '0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bf_clr_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_cur_q    <= '0;
      tw_pipe_q   <= '0;
      wr_pipe_q   <= '0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      bfly_q      <= bfly_d;
      drain_q     <= drain_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bf_clr_q    <= bf_clr_d;
      rd_valid_q  <= rd_valid_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      tw_cur_q    <= tw_cur_d;
      tw_pipe_q   <= tw_pipe_d;
      wr_pipe_q   <= wr_pipe_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stage     = stage_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_addr_a = rd_addr_a_q;
  assign bus.rd_addr_b = rd_addr_b_q;
  assign bus.tw_idx    = tw_pipe_q[RD_LAT-1];
  assign bus.bf_en     = busy_q;
  assign bus.bf_clr    = bf_clr_q;
  assign bus.wr_valid  = wr_pipe_q[WR_LAT-1].valid;
  assign bus.wr_addr_a = wr_pipe_q[WR_LAT-1].a;
  assign bus.wr_addr_b = wr_pipe_q[WR_LAT-1].b;
endmodule

// File: tb/tb_fft_bfly_sequencer.sv
// Bench for fft_bfly_sequencer: per-cycle timeline model, write-back scoreboard,
// hand-derived address vectors and multi-cycle start/reset sequences.
module tb_fft_bfly_sequencer;
  localparam int LOG2N   = 5;
  localparam int HALF    = 16;
  localparam int STG     = 21;
  localparam int RUN_LEN = 106;
  localparam int WR_DLY  = 5;

  logic clock_c = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   run_start = -1;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  bit   mon_on = 1'b0;

  typedef struct {
    int due;
    int a;
    int b;
  } wr_exp_t;
  wr_exp_t sb_q[$];

  typedef struct {
    int s;
    int b;
    int exp_a;
    int exp_b;
    int exp_tw;
  } vec_t;
  vec_t vecs[8];

  int      a_m, b_m, tw_m;
  wr_exp_t e_m;

  fft_bfly_sequencer_if #(.LOG2N(LOG2N)) bus ();

  fft_bfly_sequencer #(.LOG2N(LOG2N), .RD_LAT(1), .BF_LAT(4)) dut (
    .clock_c(clock_c),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock_c = ~clock_c;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, actual, expected);
    end
  endtask

  function automatic bit in_run(input int t);
    return (t >= 1) && (t < RUN_LEN) && (((t - 1) % STG) < HALF);
  endfunction

  function automatic void model_addr(input int t, output int a, output int b, output int tw);
    int s, k, span;
    s    = (t - 1) / STG;
    k    = (t - 1) % STG;
    span = 1 << s;
    a    = (k / span) * 2 * span + (k % span);
    b    = a + span;
    tw   = (k % span) * (HALF / span);
  endfunction

  // Reference timeline: track accepted starts and queue every expected write-back.
  always @(posedge clock_c) begin
    if (!reset_n) begin
      run_start = -1;
      sb_q.delete();
    end else if (bus.start === 1'b1 && (run_start < 0 || cyc - run_start > RUN_LEN)) begin
      run_start = cyc;
      for (int s = 0; s < LOG2N; s++) begin
        for (int k = 0; k < HALF; k++) begin
          model_addr(1 + STG * s + k, a_m, b_m, tw_m);
          e_m.due = cyc + 1 + STG * s + k + WR_DLY;
          e_m.a   = a_m;
          e_m.b   = b_m;
          sb_q.push_back(e_m);
        end
      end
    end
    cyc++;
    mon_on = 1'b1;
  end

  task automatic monitor_cycle();
    int      t, ea, eb, etw, xa, xb, xtw;
    bit      run_now, exp_wr, act;
    wr_exp_t e;
    t   = (run_start >= 0) ? cyc - run_start : -1;
    ea  = 0;
    eb  = 0;
    etw = 0;
    run_now = in_run(t);
    if (run_now) model_addr(t, ea, eb, xtw);
    if (in_run(t - 1)) model_addr(t - 1, xa, xb, etw);
    act = (t >= 1) && (t < RUN_LEN);
    check_output("rd_valid", bus.rd_valid, run_now);
    check_output("rd_addr_a", bus.rd_addr_a, ea);
    check_output("rd_addr_b", bus.rd_addr_b, eb);
    check_output("tw_idx", bus.tw_idx, etw);
    check_output("busy", bus.busy, act);
    check_output("bf_en", bus.bf_en, act);
    check_output("done", bus.done, t == RUN_LEN);
    check_output("bf_clr", bus.bf_clr, t == 1);
    if (t != RUN_LEN) check_output("stage", bus.stage, act ? (t - 1) / STG : 0);
    exp_wr = (sb_q.size() > 0) && (sb_q[0].due == cyc);
    check_output("wr_valid", bus.wr_valid, exp_wr);
    if (exp_wr) begin
      e = sb_q.pop_front();
      if (bus.wr_valid === 1'b1) begin
        check_output("wr_addr_a", bus.wr_addr_a, e.a);
        check_output("wr_addr_b", bus.wr_addr_b, e.b);
      end
    end
    if (bus.done === 1'b1) done_cnt++;
  endtask

  always @(negedge clock_c) begin
    if (mon_on) monitor_cycle();
  end

  task automatic step();
    @(posedge clock_c);
    #1;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic apply_stimulus(input logic start_v, input logic rst_v);
    bus.start = start_v;
    reset_n   = rst_v;
  endtask

  task automatic pulse_start(input int c);
    go_to(c);
    apply_stimulus(1'b1, 1'b1);
    step();
    apply_stimulus(1'b0, 1'b1);
  endtask

  initial begin
    int base, rd;
    vecs[0] = '{0,  0,  0,  1,  0};
    vecs[1] = '{0, 10, 20, 21,  0};
    vecs[2] = '{1,  5,  9, 11,  8};
    vecs[3] = '{2,  5,  9, 13,  4};
    vecs[4] = '{2, 15, 27, 31, 12};
    vecs[5] = '{3, 10, 18, 26,  4};
    vecs[6] = '{4,  5,  5, 21,  5};
    vecs[7] = '{4, 15, 15, 31, 15};

    apply_stimulus(1'b0, 1'b0);
    step();
    // A start seen together with reset must not launch a run.
    apply_stimulus(1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 1'b0);
    step();
    apply_stimulus(1'b0, 1'b1);
    #3;
    check_output("rst_busy", bus.busy, 0);
    check_output("rst_done", bus.done, 0);
    check_output("rst_stage", bus.stage, 0);
    check_output("rst_rd_valid", bus.rd_valid, 0);
    check_output("rst_wr_valid", bus.wr_valid, 0);
    check_output("rst_bf_en", bus.bf_en, 0);
    check_output("rst_bf_clr", bus.bf_clr, 0);
    check_output("rst_tw_idx", bus.tw_idx, 0);
    go_to(23);

    base = 25;
    pulse_start(base);
    for (int i = 0; i < 8; i++) begin
      rd = base + 1 + STG * vecs[i].s + vecs[i].b;
      go_to(rd);
      #3;
      check_output("vec_rd_a", bus.rd_addr_a, vecs[i].exp_a);
      check_output("vec_rd_b", bus.rd_addr_b, vecs[i].exp_b);
      step();
      #3;
      check_output("vec_tw", bus.tw_idx, vecs[i].exp_tw);
      go_to(rd + WR_DLY);
      #3;
      check_output("vec_wr_valid", bus.wr_valid, 1);
      check_output("vec_wr_a", bus.wr_addr_a, vecs[i].exp_a);
      check_output("vec_wr_b", bus.wr_addr_b, vecs[i].exp_b);
    end
    go_to(base + RUN_LEN);
    #3;
    check_output("run1_done", bus.done, 1);
    check_output("run1_busy", bus.busy, 0);
    step();
    #3;
    check_output("run1_done_pulse", bus.done, 0);

    base = 140;
    pulse_start(base);
    pulse_start(base + 10);
    pulse_start(base + 50);
    go_to(base + RUN_LEN);
    #3;
    check_output("run2_done", bus.done, 1);
    // Start held through DONE and the following idle cycle: only the idle one counts.
    apply_stimulus(1'b1, 1'b1);
    step();
    step();
    apply_stimulus(1'b0, 1'b1);
    go_to(base + 2 * RUN_LEN + 1);
    #3;
    check_output("run3_done", bus.done, 1);

    base = 360;
    pulse_start(base);
    go_to(base + 30);
    apply_stimulus(1'b0, 1'b0);
    step();
    apply_stimulus(1'b0, 1'b1);
    #3;
    check_output("midrst_busy", bus.busy, 0);
    check_output("midrst_stage", bus.stage, 0);
    check_output("midrst_rd_valid", bus.rd_valid, 0);
    pulse_start(base + 35);
    go_to(base + 141);
    #3;
    check_output("run4_done", bus.done, 1);
    go_to(base + 150);
    #3;
    check_output("done_count", done_cnt, 4);
    check_output("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/fft_bfly_sequencer.md
Name: fft_bfly_sequencer

Overview:
Control sequencer for the single-butterfly, in-place radix-2 DIT FFT engine. It walks all log2(N) stages × N/2 butterflies. For each butterfly it issues the data-RAM read addresses, the twiddle index, and the butterfly enable and clear. It issues write-back addresses delayed to match the RAM read latency plus the butterfly pipeline latency. It sits between the FFT top-level control (start/done) and the data RAM plus 8-bit complex butterfly datapath with its 16-entry twiddle ROM. Input data is loaded into RAM in bit-reversed order before start.

Parameters:
LOG2N, 5, log2 of FFT size. N=32, so 16 butterflies per stage and a 4-bit twiddle index.
RD_LAT, 1, cycles from rd_addr to RAM data at the butterfly inputs.
BF_LAT, 4, cycles from butterfly input (with bf_en=1) to butterfly output.

Ports:
clock_c  in  1  clock, all logic on rising edge
reset_n  in  1  synchronous reset, active-low
start  in  1  single-cycle request to run one full FFT; ignored while busy=1
busy  out  1  high from first RUN cycle through last DRAIN cycle
done  out  1  one-cycle pulse after the last write-back
stage  out  3  current stage index, 0..LOG2N-1
rd_valid  out  1  read addresses valid this cycle
rd_addr_a  out  LOG2N  butterfly upper-leg read address
rd_addr_b  out  LOG2N  butterfly lower-leg read address
tw_idx  out  LOG2N-1  twiddle ROM index, aligned to RAM data (delayed RD_LAT after rd_addr)
bf_en  out  1  butterfly pipeline enable
bf_clr  out  1  butterfly synchronous clear pulse (active-high)
wr_valid  out  1  write-back strobe for both legs
wr_addr_a  out  LOG2N  write address for butterfly output o1
wr_addr_b  out  LOG2N  write address for butterfly output o2

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE, stage=0, butterfly counter b=0. All outputs are 0. The address/valid delay lines are cleared, so no write strobe is issued after a mid-run reset. Reset has priority over start.
- States:
  - IDLE: start=1 → RUN, with stage=0 and b=0.
  - RUN: issues one butterfly per cycle and increments b. When b=N/2-1 is issued → DRAIN.
  - DRAIN: lasts RD_LAT+BF_LAT cycles, so every write of the stage lands before the next stage reads. At the end of DRAIN: if stage<LOG2N-1, increment stage, clear b, → RUN; else → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Addressing for stage s, butterfly b:
  - span = 2^s, group = b>>s, pos = b & (span-1).
  - rd_addr_a = (group<<(s+1)) | pos; rd_addr_b = rd_addr_a + span.
  - twiddle = pos<<(LOG2N-1-s).
- rd_valid=1 exactly in RUN cycles. rd_addr_a/b are 0 outside RUN.
- tw_idx is the twiddle delayed RD_LAT cycles.
- wr_valid, wr_addr_a and wr_addr_b are rd_valid, rd_addr_a and rd_addr_b delayed RD_LAT+BF_LAT cycles through a reset-cleared shift line.
- bf_en=1 in RUN and DRAIN, 0 in IDLE/DONE. The butterfly registers are frozen outside a run.
- bf_clr=1 only in the first RUN cycle of stage 0. It flushes stale butterfly state before the first data arrives.
- busy=1 in RUN and DRAIN.
- A start pulse during busy or DONE is dropped, not queued.
- Cycle count with start in cycle 0:
  - Stage s RUN covers cycles 1+21s..16+21s; DRAIN covers 17+21s..21+21s.
  - done=1 in cycle 106.
  - A new start is accepted in cycle 107 or later.

Test Plan:
- Reset/idle: hold reset_n=0 for 3 cycles, then release → all outputs 0; busy=0; no wr_valid for 20 idle cycles.
- Full run: pulse start in cycle 0 → rd_valid high in cycles 1-16, 22-37, 43-58, 64-79, 85-100; first wr_valid in cycle 6; 80 wr_valid cycles total; done=1 only in cycle 106; busy low by cycle 106.
- Address check at b=5 → s0: a=10, b=11, tw=0; s1: a=9, b=11, tw=8; s2: a=9, b=13, tw=4; s4: a=5, b=21, tw=5. tw_idx lags rd_addr by 1 cycle; wr_addr matches rd_addr 5 cycles later.
- Start while busy: extra start pulses in cycles 10 and 50 → timeline identical to the full run; exactly one done.
- Reset mid-run: reset_n=0 in cycle 30 → cycle 31: IDLE, busy=0, stage=0; no wr_valid afterwards; a start in cycle 35 gives done in cycle 141.
- Back-to-back runs: start in cycle 107 after the first done → second done in cycle 213; bf_clr pulses in cycles 1 and 108 only.
